// File: rtl/int_vector_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : int_vector_pkg
// Purpose  : Shared types and constants for the interrupt vector controller:
//            FSM state encodings, register addresses, injection source codes
//            and the default vector addresses.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package int_vector_pkg;

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_IDLE = 2'd1,
    S_INJ  = 2'd2
  } state_t;

  localparam logic [1:0] REG_MASK_LO = 2'd0;
  localparam logic [1:0] REG_MASK_HI = 2'd1;
  localparam logic [1:0] REG_PEND    = 2'd2;
  localparam logic [1:0] REG_ISR_EOI = 2'd3;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_HYP  = 2'd1,
    SRC_NMI  = 2'd2,
    SRC_IRQ  = 2'd3
  } src_t;

  localparam logic [15:0] DEF_VEC_BASE = 16'hFFC0;
  localparam logic [15:0] DEF_NMI_VEC  = 16'hFFFA;
  localparam logic [15:0] DEF_RST_VEC  = 16'hFFFC;
  localparam logic [15:0] DEF_HYP_VEC  = 16'hFF00;

endpackage
`default_nettype wire

// File: rtl/int_vector_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : int_vector_ctrl_if
// Purpose  : CPU-visible register port of the interrupt vector controller.
// Signals  : reg_we    - write strobe
//            reg_addr  - register select (see REG_* in int_vector_pkg)
//            reg_wdata - write data
//            reg_rdata - read data (combinational from the controller)
// Modports : master (CPU side), slave (controller side)
// Revision : 1.0 - initial release
// ============================================================================
interface int_vector_ctrl_if;
  import int_vector_pkg::*;

  logic       reg_we;
  logic [1:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;

  modport master (output reg_we, output reg_addr, output reg_wdata, input reg_rdata);
  modport slave  (input reg_we, input reg_addr, input reg_wdata, output reg_rdata);

endinterface
`default_nettype wire

// File: rtl/int_vector_ctrl_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : int_prio_enc
// Purpose  : Lowest-index-wins priority encoder.
// Ports    : req   in  WIDTH  request vector
//            valid out 1      any request set
//            idx   out 4      index of the lowest set request (0 if none)
// Revision : 1.0 - initial release
// ============================================================================
module int_prio_enc
  import int_vector_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic [WIDTH-1:0] req,
  output logic                  valid,
  output logic [3:0]            idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = 4'd0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 4'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/int_vector_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : int_vector_ctrl
// Purpose  : Interrupt arbitration and injection for the core. Arbitrates
//            hypervisor trap, NMI and NUM_IRQ maskable level sources at
//            instruction boundaries, with per-channel masks, per-channel
//            vectors, in-service nesting and EOI via a register port.
// Ports    : clk, reset (async, active low), ready, mc_sync, i_flag,
//            i_flag_load, hyper_mode, irq[NUM_IRQ], nmi, hyp   - inputs
//            regs (int_vector_ctrl_if.slave)                 - register port
//            intg, nmig, hyperg, resp, pc_hold, vector_hi, vector_lo,
//            irq_id                                          - outputs
// Revision : 1.0 - initial release
// ============================================================================
module int_vector_ctrl
  import int_vector_pkg::*;
#(
  parameter int          NUM_IRQ  = 8,
  parameter logic [15:0] VEC_BASE = DEF_VEC_BASE,
  parameter logic [15:0] NMI_VEC  = DEF_NMI_VEC,
  parameter logic [15:0] RST_VEC  = DEF_RST_VEC,
  parameter logic [15:0] HYP_VEC  = DEF_HYP_VEC
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               ready,
  input  wire logic               mc_sync,
  input  wire logic               i_flag,
  input  wire logic               i_flag_load,
  input  wire logic               hyper_mode,
  input  wire logic [NUM_IRQ-1:0] irq,
  input  wire logic               nmi,
  input  wire logic               hyp,
  int_vector_ctrl_if.slave        regs,
  output logic                    intg,
  output logic                    nmig,
  output logic                    hyperg,
  output logic                    resp,
  output logic                    pc_hold,
  output logic [7:0]              vector_hi,
  output logic [7:0]              vector_lo,
  output logic [3:0]              irq_id
);

  state_t             state;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] isr;
  logic               nmi_d;
  logic               pend_nmi;
  logic               i_pre;
  logic [15:0]        vec;

  logic               boundary;
  logic               eff_i;
  logic [NUM_IRQ-1:0] blocked;
  logic [NUM_IRQ-1:0] elig;
  logic               irq_ok;
  logic [3:0]         irq_idx;
  logic               isr_any;
  logic [3:0]         isr_low;
  logic               hyp_ok;
  logic               nmi_ok;
  logic               take;
  src_t               sel_src;
  logic               take_nmi;
  logic               take_irq;
  logic               wr;
  logic               eoi;
  logic [NUM_IRQ-1:0] mask_next;
  logic [NUM_IRQ-1:0] isr_set;
  logic [NUM_IRQ-1:0] isr_clr;
  logic [7:0]         rdata;
  logic [15:0]        chan_vec;

  assign boundary = mc_sync & ready;

  // CLI/SEI take effect one instruction late: while the current instruction
  // writes I, arbitration uses the I value snapshotted at the last boundary.
  assign eff_i = i_flag_load ? i_pre : i_flag;

  // Channel k is blocked for nesting when any isr bit at or below k is set.
  always_comb begin
    logic acc;
    acc     = 1'b0;
    blocked = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      acc        = acc | isr[k];
      blocked[k] = acc;
    end
  end

  assign elig = irq & ~mask & ~blocked & {NUM_IRQ{~eff_i & ~hyper_mode}};

  int_prio_enc #(.WIDTH(NUM_IRQ)) u_take_enc (
    .req   (elig),
    .valid (irq_ok),
    .idx   (irq_idx)
  );

  int_prio_enc #(.WIDTH(NUM_IRQ)) u_eoi_enc (
    .req   (isr),
    .valid (isr_any),
    .idx   (isr_low)
  );

  assign hyp_ok = hyp & ~hyper_mode;
  assign nmi_ok = pend_nmi & ~hyper_mode;
  assign take   = boundary && (state == S_IDLE) && (hyp_ok || nmi_ok || irq_ok);

  always_comb begin
    sel_src = SRC_NONE;
    if (hyp_ok)      sel_src = SRC_HYP;
    else if (nmi_ok) sel_src = SRC_NMI;
    else if (irq_ok) sel_src = SRC_IRQ;
  end

  assign take_nmi = take && (sel_src == SRC_NMI);
  assign take_irq = take && (sel_src == SRC_IRQ);
  assign chan_vec = VEC_BASE + {11'd0, irq_idx, 1'b0};

  // Register writes; upper mask bits beyond NUM_IRQ simply do not exist.
  assign wr  = regs.reg_we & ready;
  assign eoi = wr && (regs.reg_addr == REG_ISR_EOI) && isr_any;

  always_comb begin
    mask_next = mask;
    isr_set   = '0;
    isr_clr   = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (wr && (regs.reg_addr == REG_MASK_LO) && (k < 8))
        mask_next[k] = regs.reg_wdata[k % 8];
      if (wr && (regs.reg_addr == REG_MASK_HI) && (k >= 8))
        mask_next[k] = regs.reg_wdata[k % 8];
      isr_set[k] = take_irq && (irq_idx == 4'(k));
      isr_clr[k] = eoi && (isr_low == 4'(k));
    end
  end

  always_comb begin
    rdata = 8'h00;
    for (int k = 0; k < NUM_IRQ; k++) begin
      case (regs.reg_addr)
        REG_MASK_LO: if (k < 8)  rdata[k % 8] = mask[k];
        REG_MASK_HI: if (k >= 8) rdata[k % 8] = mask[k];
        REG_PEND:    if (k < 8)  rdata[k % 8] = irq[k] & ~mask[k];
        default:     if (k < 8)  rdata[k % 8] = isr[k];
      endcase
    end
  end

  assign regs.reg_rdata = rdata;

  // NMI edge detection runs regardless of ready so no edge is lost during a
  // stall. A new edge in the same cycle as an NMI take keeps pend_nmi set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nmi_d    <= 1'b0;
      pend_nmi <= 1'b0;
    end else begin
      nmi_d    <= nmi;
      pend_nmi <= (nmi & ~nmi_d) | (pend_nmi & ~take_nmi);
    end
  end

  // Mask, in-service and I snapshot. A take and a register write in the same
  // cycle both apply; arbitration above already used the pre-write mask.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask  <= '0;
      isr   <= '0;
      i_pre <= 1'b1;
    end else if (ready) begin
      mask <= mask_next;
      isr  <= (isr & ~isr_clr) | isr_set;
      if (mc_sync) i_pre <= i_flag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_RST;
      intg    <= 1'b0;
      nmig    <= 1'b0;
      hyperg  <= 1'b0;
      resp    <= 1'b1;
      pc_hold <= 1'b0;
      vec     <= RST_VEC;
      irq_id  <= 4'd0;
    end else if (ready) begin
      case (state)
        S_RST: begin
          if (mc_sync) begin
            state   <= S_IDLE;
            intg    <= 1'b0;
            pc_hold <= 1'b0;
            resp    <= 1'b0;
          end else begin
            intg    <= 1'b1;
            pc_hold <= 1'b1;
          end
        end
        S_IDLE: begin
          if (take) begin
            state   <= S_INJ;
            intg    <= 1'b1;
            pc_hold <= 1'b1;
            nmig    <= (sel_src == SRC_NMI);
            hyperg  <= (sel_src == SRC_HYP);
            irq_id  <= (sel_src == SRC_IRQ) ? irq_idx : 4'd0;
            case (sel_src)
              SRC_HYP: vec <= HYP_VEC;
              SRC_NMI: vec <= NMI_VEC;
              default: vec <= chan_vec;
            endcase
          end
        end
        S_INJ: begin
          // Leave without arbitrating so one handler instruction always runs.
          if (mc_sync) begin
            state   <= S_IDLE;
            intg    <= 1'b0;
            nmig    <= 1'b0;
            hyperg  <= 1'b0;
            pc_hold <= 1'b0;
            irq_id  <= 4'd0;
          end
        end
        default: state <= S_RST;
      endcase
    end
  end

  assign vector_hi = vec[15:8];
  assign vector_lo = vec[7:0];

endmodule
`default_nettype wire
